// File: rtl/alu4_seq_pkg.sv
// Shared definitions for the ALU sequencing stage: opcode encodings and FSM states.
package alu4_seq_pkg;

  // Opcodes understood by the 4-bit combinational ALU
  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  // Sequencer states: accept a request, let the ALU settle, present the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_seq.sv
// Sequencing stage around the 4-bit ALU. Requests are latched into the ALU
// operand registers, the ALU output is captured one cycle later, and the
// result is offered downstream until it is taken. An accumulator keeps the
// last result for chained operations; o_op_cnt counts delivered results.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Upstream (i_valid/o_ready) and downstream (o_valid/i_ready) both
// follow this rule; o_ready and o_valid depend on the state only, so neither
// has a combinational path from the other side's valid/ready.
module alu4_seq
  import alu4_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  // upstream request
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_op,
  input  logic       i_chain,
  // ALU side
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  // downstream result
  output logic       o_valid,
  input  logic       i_ready,
  output logic [3:0] o_result,
  output logic       o_c,
  output logic       o_n,
  output logic       o_z,
  output logic       o_v,
  output logic [3:0] o_acc,
  output logic [7:0] o_op_cnt,
  // debug visibility of the sequencer state
  output state_t     o_state
);

  state_t     state_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic [3:0] result_q;
  logic       c_q;
  logic       n_q;
  logic       z_q;
  logic       v_q;
  logic [3:0] acc_q;
  logic [7:0] op_cnt_q;

  // Sequencer FSM with operand, capture, accumulator and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      alu_op_q <= 3'd0;
      result_q <= 4'd0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      acc_q    <= 4'd0;
      op_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            // Chained requests read the accumulator left by the last completed op
            alu_a_q  <= i_chain ? acc_q : i_a;
            alu_b_q  <= i_b;
            alu_op_q <= i_op;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU has settled from the registered operands during this cycle
          result_q <= alu_result;
          acc_q    <= alu_result;
          c_q      <= alu_c;
          n_q      <= alu_n;
          z_q      <= alu_z;
          v_q      <= alu_v;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (i_ready) begin
            op_cnt_q <= op_cnt_q + 8'd1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the state register alone
  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_valid = (state_q == ST_DONE);
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign o_result = result_q;
  assign o_c      = c_q;
  assign o_n      = n_q;
  assign o_z      = z_q;
  assign o_v      = v_q;
  assign o_acc    = acc_q;
  assign o_op_cnt = op_cnt_q;
  assign o_state  = state_q;

endmodule
